// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter
//  Description : Loadable up/down counter with a programmable step and a
//                programmable upper bound (range 0..max_val inclusive).
//                At a range boundary the counter either wraps to the other
//                end or saturates, depending on SATURATE. It raises a
//                one-cycle terminal-count pulse and sets a sticky
//                boundary-event flag.
//  Ports       : clk      - clock, rising edge active
//                rst      - synchronous active-high reset
//                en       - count enable (one step per cycle)
//                dir      - 1 = up, 0 = down
//                step     - unsigned step amount (STEP_W bits)
//                load     - synchronous load strobe (beats en)
//                load_val - value to load, clamped to max_val
//                max_val  - inclusive upper bound of the count range
//                clr_ovf  - clears the sticky flag (a set on the same edge wins)
//                count    - registered count
//                tc       - registered terminal-count pulse
//                ovf      - registered sticky boundary-event flag
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf
);

  localparam logic c_saturate = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             boundary;

  // Work one bit wider than the count so that the up sum cannot overflow.
  assign step_ext = (WIDTH+1)'(step);
  assign sum      = {1'b0, count_q} + step_ext;
  assign diff     = count_q - step_ext[WIDTH-1:0];

  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    boundary = 1'b0;

    if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
    end else if (en && (step != '0)) begin
      if (count_q > max_val) begin
        // max_val was lowered below the current count: any real step is
        // treated as a boundary crossing, whatever the direction.
        boundary = 1'b1;
      end else if (dir) begin
        if (sum > {1'b0, max_val}) boundary = 1'b1;
        else                       count_d  = sum[WIDTH-1:0];
      end else begin
        if ({1'b0, count_q} >= step_ext) count_d  = diff;
        else                             boundary = 1'b1;
      end

      // Up+saturate and down+wrap both land on max_val; the other two
      // combinations land on 0.
      if (boundary) begin
        count_d = (dir == c_saturate) ? max_val : '0;
      end
    end

    tc_d = boundary;

    if (boundary)     ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_counter
//  Description : Self-checking bench for updown_counter. It drives a wrap-mode
//                instance and a saturate-mode instance from the same inputs
//                and checks both against an integer reference model and
//                against directed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, load, clr_ovf;
  logic [3:0] step;
  logic [7:0] load_val, max_val;

  logic [7:0] cnt  [2];
  logic       tcv  [2];
  logic       ovfv [2];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: index 0 = wrap mode, index 1 = saturate mode
  int m_count [2];
  bit m_tc    [2];
  bit m_ovf   [2];

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8), .STEP_W(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .count(cnt[0]), .tc(tcv[0]), .ovf(ovfv[0])
  );

  updown_counter #(.WIDTH(8), .STEP_W(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .count(cnt[1]), .tc(tcv[1]), .ovf(ovfv[1])
  );

  // Behavioural model: signed integer arithmetic on the range rules.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_count[m] = 0; m_tc[m] = 0; m_ovf[m] = 0;
      end else begin
        int  target;
        bit  crossed;
        crossed = 0;
        m_tc[m] = 0;
        if (load) begin
          m_count[m] = (int'(load_val) < int'(max_val)) ? int'(load_val) : int'(max_val);
        end else if (en && step != 0) begin
          target = dir ? m_count[m] + int'(step) : m_count[m] - int'(step);
          if (m_count[m] > int'(max_val) || target > int'(max_val) || target < 0) begin
            crossed = 1;
            if (m == 0) m_count[m] = dir ? 0 : int'(max_val);
            else        m_count[m] = dir ? int'(max_val) : 0;
          end else begin
            m_count[m] = target;
          end
        end
        m_tc[m] = crossed;
        if (crossed)      m_ovf[m] = 1;
        else if (clr_ovf) m_ovf[m] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    rst = 0; en = 0; dir = 0; load = 0; clr_ovf = 0;
    step = 4'd0; load_val = 8'd0; max_val = 8'd0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; en = 1; load = 1; load_val = 8'd77; max_val = 8'd200; step = 4'd3;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cnt[k] !== 8'd0 || tcv[k] !== 1'b0 || ovfv[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: count=%0d tc=%b ovf=%b, want 0 0 0", k, cnt[k], tcv[k], ovfv[k]);
      end
    end
  endtask

  task automatic test_wrap_up();
    int exp_c;
    set_idle();
    rst = 1; tick();
    rst = 0; en = 1; dir = 1; step = 4'd1; max_val = 8'd9;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_c = (i + 1) % 10;
      vectors++;
      if (cnt[0] !== 8'(exp_c) || tcv[0] !== (i == 9) || ovfv[0] !== (i >= 9)) begin
        miscompares++;
        $display("FAIL wrap_up cyc %0d: count=%0d tc=%b ovf=%b, want %0d %b %b",
                 i, cnt[0], tcv[0], ovfv[0], exp_c, (i == 9), (i >= 9));
      end
    end
  endtask

  task automatic test_sat_load();
    set_idle();
    load = 1; load_val = 8'd198; max_val = 8'd200;
    tick();
    vectors++;
    if (cnt[1] !== 8'd198 || tcv[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_load: count=%0d tc=%b, want 198 0", cnt[1], tcv[1]);
    end
    load = 0; en = 1; dir = 1; step = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (cnt[1] !== 8'd200 || tcv[1] !== 1'b1 || ovfv[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_up cyc %0d: count=%0d tc=%b ovf=%b, want 200 1 1", i, cnt[1], tcv[1], ovfv[1]);
      end
    end
  endtask

  task automatic test_down_wrap();
    set_idle();
    load = 1; load_val = 8'd2; max_val = 8'd15;
    tick();
    load = 0; en = 1; dir = 0; step = 4'd5;
    tick();
    vectors++;
    if (cnt[0] !== 8'd15 || tcv[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL down_wrap: count=%0d tc=%b, want 15 1", cnt[0], tcv[0]);
    end
    vectors++;
    if (cnt[1] !== 8'd0 || tcv[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL down_sat: count=%0d tc=%b, want 0 1", cnt[1], tcv[1]);
    end
    tick();
    vectors++;
    if (cnt[0] !== 8'd10 || tcv[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL down_step: count=%0d tc=%b, want 10 0", cnt[0], tcv[0]);
    end
  endtask

  task automatic test_load_priority();
    set_idle();
    load = 1; en = 1; dir = 1; step = 4'd1; load_val = 8'd50; max_val = 8'd40;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cnt[k] !== 8'd40 || tcv[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL load_clamp[%0d]: count=%0d tc=%b, want 40 0", k, cnt[k], tcv[k]);
      end
    end
    load = 0; clr_ovf = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ovfv[k] !== 1'b1 || tcv[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL set_beats_clr[%0d]: ovf=%b tc=%b, want 1 1", k, ovfv[k], tcv[k]);
      end
    end
    en = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ovfv[k] !== 1'b0 || tcv[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL clr_ovf[%0d]: ovf=%b tc=%b, want 0 0", k, ovfv[k], tcv[k]);
      end
    end
  endtask

  task automatic test_max_lowered();
    set_idle();
    load = 1; load_val = 8'd7; max_val = 8'd10;
    tick();
    load = 0; en = 1; dir = 0; step = 4'd1; max_val = 8'd5;
    tick();
    vectors++;
    if (cnt[0] !== 8'd5 || tcv[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL max_lowered_wrap: count=%0d tc=%b, want 5 1", cnt[0], tcv[0]);
    end
    vectors++;
    if (cnt[1] !== 8'd0 || tcv[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL max_lowered_sat: count=%0d tc=%b, want 0 1", cnt[1], tcv[1]);
    end
  endtask

  task automatic test_reset_mid();
    set_idle();
    max_val = 8'd9; en = 1; dir = 1; step = 4'd5;
    load = 1; load_val = 8'd8; tick();
    load = 0; tick();                 // 8+5 crosses the bound, so ovf is now set
    rst = 1; load = 1; load_val = 8'd3; clr_ovf = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cnt[k] !== 8'd0 || tcv[k] !== 1'b0 || ovfv[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: count=%0d tc=%b ovf=%b, want 0 0 0", k, cnt[k], tcv[k], ovfv[k]);
      end
    end
    rst = 0; load = 0; step = 4'd1;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cnt[k] !== 8'd1 || tcv[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL resume[%0d]: count=%0d tc=%b, want 1 0", k, cnt[k], tcv[k]);
      end
    end
  endtask

  task automatic test_step_zero();
    set_idle();
    load = 1; load_val = 8'd0; max_val = 8'd0;
    tick();
    load = 0; en = 1; dir = 0; step = 4'd0;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cnt[k] !== 8'd0 || tcv[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL step_zero[%0d]: count=%0d tc=%b, want 0 0", k, cnt[k], tcv[k]);
      end
    end
    step = 4'd2; dir = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cnt[k] !== 8'd0 || tcv[k] !== 1'b1 || ovfv[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL max_zero[%0d]: count=%0d tc=%b ovf=%b, want 0 1 1", k, cnt[k], tcv[k], ovfv[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 4) != 0);
      dir      = 1'($urandom_range(0, 1));
      clr_ovf  = ($urandom_range(0, 3) == 0);
      step     = 4'($urandom_range(0, 15));
      load_val = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       max_val = 8'($urandom_range(0, 3));
        1:       max_val = 8'($urandom_range(0, 20));
        2:       max_val = 8'd255;
        default: max_val = 8'($urandom_range(0, 255));
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (cnt[k] !== 8'(m_count[k]) || tcv[k] !== m_tc[k] || ovfv[k] !== m_ovf[k]) begin
          miscompares++;
          $display("FAIL random[%0d] cyc %0d: count=%0d tc=%b ovf=%b, want %0d %b %b",
                   k, i, cnt[k], tcv[k], ovfv[k], m_count[k], m_tc[k], m_ovf[k]);
        end
      end
    end
  endtask

  initial begin
    set_idle();
    rst = 1;
    test_reset();
    test_wrap_up();
    test_sat_load();
    test_down_wrap();
    test_load_priority();
    test_max_lowered();
    test_reset_mid();
    test_step_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
